transpose_buffer: RTL and testbench
===================================

# transpose_buffer

Double-buffered 8x8 transpose memory between the row-DCT stage and the column-DCT stage of the 8-point 2D DCT. It accepts row-DCT coefficients in raster order, one per cycle, and stores them in a 64-word bank. It replays each full bank in column order to the column-DCT stage. Two banks ping-pong, so a new block can be written while the previous one drains.

## Interface

Parameters:
- N, 8, transform size; the bank holds N*N words
- DATA_W, 12, coefficient width in bits (two's complement, passed through untouched)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  DATA_W  row-DCT coefficient
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  buffer can accept in_data this cycle
- out_data  output  DATA_W  coefficient in transposed order
- out_valid  output  1  out_data is valid this cycle
- out_ready  input  1  column stage accepts out_data this cycle
- out_last  output  1  qualifies out_data as the final (64th) word of a block
- bank_full  output  2  per-bank full flags, for status/debug

## Operation

State:
- mem[2][N*N]: two banks of DATA_W registers.
- wsel, rsel: 1-bit bank pointers.
- wcnt, rcnt: 6-bit counters (log2(N*N) bits).
- full[1:0]: per-bank full flags.

Write side:
- in_ready = !full[wsel].
- Write transfer: in_valid && in_ready.
- On a transfer, mem[wsel][wcnt] <= in_data and wcnt increments.
- Input order is raster: index = row*N + col, with col varying fastest.
- On the transfer with wcnt == N*N-1: wcnt wraps to 0, full[wsel] sets, and wsel toggles.

Read side:
- out_valid = full[rsel].
- out_data = mem[rsel][raddr], where raddr = (rcnt mod N)*N + (rcnt div N).
- This gives column order: element (row=rcnt mod N, col=rcnt div N).
- out_last = out_valid && (rcnt == N*N-1).
- Read transfer: out_valid && out_ready. On a transfer, rcnt increments.
- On the transfer with rcnt == N*N-1: rcnt wraps to 0, full[rsel] clears, and rsel toggles.

Boundary conditions:
- Simultaneous events on different banks: the write side setting full on one bank and the read side clearing full on the other bank in the same edge are both honoured.
- Same-bank conflict:
  - The read side may clear full[b] on the same edge the write side would need bank b.
  - in_ready uses the registered flag, so writes to b resume the next cycle. There is no bypass.
  - full[b] never sets and clears on the same edge, because a bank must be full before it is read.
- Both banks full: in_ready stays low until the read side frees a bank. No data is lost or overwritten.
- Input idle: when in_valid is low, nothing changes on the write side. Partial blocks stay pending indefinitely.
- Output stall: when out_ready is low, out_data, out_last and rcnt hold.
- Reset is asynchronous at any time, including mid-block:
  - wsel, rsel, wcnt, rcnt and full all go to 0.
  - Memory contents are not reset and their values are don't-care.
  - Any partial block in progress is discarded.

Reset values of outputs:
- in_ready = 1
- out_valid = 0
- out_last = 0
- bank_full = 2'b00
- out_data = don't-care (bench must not check it while out_valid = 0)

## Timing

- Write-to-read latency: out_valid rises in the cycle after the edge that accepts the 64th word of a block.
- Throughput: with out_ready held high, sustained throughput is one word per cycle on both sides. A continuous input stream never sees in_ready low.
- Output path:
  - out_data is a combinational mux from registers; there is no extra pipeline stage.
  - The downstream stage must register it.
- Input path: in_ready depends only on registers, with no combinational path from out_ready.

## Structure

- Shared package dct_pkg holds:
  - N, DATA_W, ADDR_W = $clog2(N*N)
  - the coefficient typedef coef_t (logic signed [DATA_W-1:0])
- One natural sub-module, transpose_addr, generates raddr from rcnt as a pure combinational bit swap: {rcnt[2:0], rcnt[5:3]} for N = 8.
- Bank storage and control stay in transpose_buffer.

## Test plan

1. **Single block:** after reset, write in_data = 0..63 with out_ready low.
   - Required: in_ready stays 1 and bank_full = 2'b01 after the 64th word.
   - Then raise out_ready. Required: out_data = 0,8,16,…,56,1,9,…,63 over 64 cycles, with out_last only on the 63.
2. **Back-to-back:** stream three blocks (values 0..63, 64..127, 128..191) with out_ready = 1.
   - Required: in_ready is never 0.
   - Required: each block is output transposed, the first valid word appears 1 cycle after the 64th write, and there are no gaps.
3. **Backpressure:** hold out_ready = 0 and drive 130 words.
   - Required: in_ready drops after word 128 and bank_full = 2'b11.
   - Pulse out_ready for 64 cycles. Required: in_ready returns 1 cycle after out_last is accepted, and words 129–130 land in bank 0.
4. **Random stalls:** drive in_valid and out_ready at random with 50% probability for 20 blocks.
   - Required: the scoreboard matches transposed order exactly, and out_data/out_last hold during stalls.
5. **Reset mid-block:** assert rst_n = 0 after 37 writes and during a read at rcnt = 10.
   - Required: out_valid = 0 and in_ready = 1 immediately (asynchronously).
   - A fresh 64-word block afterwards must output correctly from index 0.

Source files
------------

// File: rtl/dct_pkg.sv
// Parameters and types shared between the DCT stages.
// The row stage, the column stage and the transpose buffer all use them.
package dct_pkg;

    localparam int N      = 8;
    localparam int DATA_W = 12;
    localparam int ADDR_W = $clog2(N * N);

    typedef logic signed [DATA_W-1:0] coef_t;

endpackage : dct_pkg

// File: rtl/transpose_addr.sv
// Maps the read counter to the raster address of element (rcnt mod N, rcnt div N).
// This is a pure bit swap of the counter's low and high halves.
module transpose_addr #(
    parameter int N = dct_pkg::N
) (
    input  logic [2*$clog2(N)-1:0] rcnt,
    output logic [2*$clog2(N)-1:0] raddr
);

    localparam int L = $clog2(N);

    // raddr = {rcnt[L-1:0], rcnt[2L-1:L]}
    for (genvar gi = 0; gi < L; gi++) begin : g_swap
        assign raddr[gi + L] = rcnt[gi];
        assign raddr[gi]     = rcnt[gi + L];
    end

endmodule : transpose_addr

// File: rtl/transpose_buffer.sv
// Ping-pong 8x8 transpose memory between the row-DCT and column-DCT stages.
// It fills one bank in raster order while the other bank drains in column order.
module transpose_buffer #(
    parameter int N      = dct_pkg::N,
    parameter int DATA_W = dct_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [1:0]        bank_full
);

    localparam int              WORDS = N * N;
    localparam int              AW    = $clog2(WORDS);
    localparam logic [AW-1:0]   LAST  = AW'(WORDS - 1);

    logic              wsel_q, wsel_d;
    logic              rsel_q, rsel_d;
    logic [AW-1:0]     wcnt_q, wcnt_d;
    logic [AW-1:0]     rcnt_q, rcnt_d;
    logic [1:0]        full_q, full_d;
    logic [AW-1:0]     raddr;
    logic              wr_fire;
    logic              rd_fire;

    logic [DATA_W-1:0] mem [2][WORDS];

    assign in_ready  = !full_q[wsel_q];
    assign out_valid = full_q[rsel_q];
    assign out_last  = out_valid && (rcnt_q == LAST);
    assign bank_full = full_q;
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;

    transpose_addr #(.N(N)) u_addr (
        .rcnt  (rcnt_q),
        .raddr (raddr)
    );

    // The read port is a plain mux; the column stage registers it.
    assign out_data = mem[rsel_q][raddr];

    // Storage is not reset; a bank's contents only matter once it is full.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        always_ff @(posedge clk) begin
            if (wr_fire && (wsel_q == 1'(gi))) begin
                mem[gi][wcnt_q] <= in_data;
            end
        end
    end

    // A bank is only written while empty and only read while full, so a
    // write-side set and a read-side clear never target the same flag.
    always_comb begin
        wsel_d = wsel_q;
        rsel_d = rsel_q;
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        full_d = full_q;

        if (wr_fire) begin
            if (wcnt_q == LAST) begin
                wcnt_d         = '0;
                full_d[wsel_q] = 1'b1;
                wsel_d         = !wsel_q;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end

        if (rd_fire) begin
            if (rcnt_q == LAST) begin
                rcnt_d         = '0;
                full_d[rsel_q] = 1'b0;
                rsel_d         = !rsel_q;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
            wcnt_q <= '0;
            rcnt_q <= '0;
            full_q <= 2'b00;
        end else begin
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
            full_q <= full_d;
        end
    end

endmodule : transpose_buffer

// File: tb/tb_transpose_buffer.sv
// Directed and randomised checks of the ping-pong transpose buffer.
// Input words carry their global stream index, so expected output is computable.
module tb_transpose_buffer;
    import dct_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [1:0]        bank_full;

    int n_cmp  = 0;
    int n_fail = 0;
    int in_cnt = 0;
    int out_cnt = 0;

    transpose_buffer #(.N(N), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .bank_full (bank_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word j of the stream: block j/64, element (row=k%8, col=k/8).
    function automatic logic [DATA_W-1:0] exp_data(input int j);
        int k;
        k = j % 64;
        return DATA_W'((j / 64) * 64 + (k % 8) * 8 + k / 8);
    endfunction

    function automatic logic exp_valid();
        return out_cnt < (in_cnt / 64) * 64;
    endfunction

    function automatic logic exp_ready();
        return ((in_cnt / 64) - (out_cnt / 64)) < 2;
    endfunction

    function automatic logic [1:0] exp_full();
        logic [1:0] m;
        m = 2'b00;
        for (int b = out_cnt / 64; b < in_cnt / 64; b++) m[b % 2] = 1'b1;
        return m;
    endfunction

    task automatic drive(input logic iv, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = DATA_W'(in_cnt);
        out_ready = ordy;
        #1;
    endtask

    task automatic commit();
        if (in_valid && in_ready) in_cnt++;
        if (out_valid && out_ready) out_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        in_cnt  = 0;
        out_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #2;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        n_cmp++;
        if (bank_full !== 2'b00) begin n_fail++; $display("FAIL reset_bank_full: got %b want 00", bank_full); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_single_block();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b0);
            n_cmp++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: word %0d got %b want 1", i, in_ready); end
            commit();
        end
        drive(1'b0, 1'b0);
        n_cmp++;
        if (bank_full !== 2'b01) begin n_fail++; $display("FAIL single_bank_full: got %b want 01", bank_full); end
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b1);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp_data(out_cnt)) begin
                n_fail++;
                $display("FAIL single_data: idx %0d got v=%b d=%0d want v=1 d=%0d", i, out_valid, out_data, exp_data(out_cnt));
            end
            n_cmp++;
            if (out_last !== (i == 63)) begin n_fail++; $display("FAIL single_last: idx %0d got %b want %b", i, out_last, i == 63); end
            commit();
        end
        drive(1'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0 || bank_full !== 2'b00) begin
            n_fail++;
            $display("FAIL single_drained: got v=%b full=%b want v=0 full=00", out_valid, bank_full);
        end
        $display("test_single_block done: %0d words out", out_cnt);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 300 && out_cnt < 192; c++) begin
            drive(in_cnt < 192, 1'b1);
            n_cmp++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: cycle %0d got %b want 1", c, in_ready); end
            n_cmp++;
            if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL b2b_out_valid: cycle %0d got %b want %b", c, out_valid, exp_valid()); end
            if (exp_valid()) begin
                n_cmp++;
                if (out_data !== exp_data(out_cnt) || out_last !== (out_cnt % 64 == 63)) begin
                    n_fail++;
                    $display("FAIL b2b_data: word %0d got d=%0d l=%b want d=%0d l=%b", out_cnt, out_data, out_last, exp_data(out_cnt), out_cnt % 64 == 63);
                end
            end
            commit();
        end
        n_cmp++;
        if (out_cnt != 192) begin n_fail++; $display("FAIL b2b_count: got %0d want 192", out_cnt); end
        $display("test_back_to_back done: %0d words out", out_cnt);
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 200 && in_cnt < 128; c++) begin
            drive(1'b1, 1'b0);
            n_cmp++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill_ready: word %0d got %b want 1", in_cnt, in_ready); end
            commit();
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0);
            n_cmp++;
            if (in_ready !== 1'b0 || bank_full !== 2'b11) begin
                n_fail++;
                $display("FAIL bp_stalled: got rdy=%b full=%b want rdy=0 full=11", in_ready, bank_full);
            end
            commit();
        end
        for (int c = 0; c < 100 && (in_cnt < 130 || out_cnt < 64); c++) begin
            drive(in_cnt < 130, out_cnt < 64);
            n_cmp++;
            if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL bp_in_ready: out %0d got %b want %b", out_cnt, in_ready, exp_ready()); end
            n_cmp++;
            if (out_valid !== exp_valid() || (exp_valid() && out_data !== exp_data(out_cnt))) begin
                n_fail++;
                $display("FAIL bp_data: word %0d got v=%b d=%0d want v=%b d=%0d", out_cnt, out_valid, out_data, exp_valid(), exp_data(out_cnt));
            end
            commit();
        end
        drive(1'b0, 1'b0);
        n_cmp++;
        if (in_cnt != 130 || bank_full !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_final: got words=%0d full=%b want words=130 full=10", in_cnt, bank_full);
        end
        $display("test_backpressure done: %0d in, %0d out", in_cnt, out_cnt);
    endtask

    task automatic test_random_stalls();
        logic              pv;
        logic              pr;
        logic              pl;
        logic [DATA_W-1:0] pd;
        pv = 1'b0;
        pr = 1'b0;
        pl = 1'b0;
        pd = '0;
        do_reset();
        for (int c = 0; c < 20000 && out_cnt < 1280; c++) begin
            drive(($urandom % 2 == 0) && (in_cnt < 1280), $urandom % 2 == 0);
            n_cmp++;
            if (in_ready !== exp_ready() || out_valid !== exp_valid() || bank_full !== exp_full()) begin
                n_fail++;
                $display("FAIL rand_flags: cycle %0d got rdy=%b v=%b full=%b want rdy=%b v=%b full=%b",
                         c, in_ready, out_valid, bank_full, exp_ready(), exp_valid(), exp_full());
            end
            if (exp_valid()) begin
                n_cmp++;
                if (out_data !== exp_data(out_cnt) || out_last !== (out_cnt % 64 == 63)) begin
                    n_fail++;
                    $display("FAIL rand_data: word %0d got d=%0d l=%b want d=%0d l=%b", out_cnt, out_data, out_last, exp_data(out_cnt), out_cnt % 64 == 63);
                end
            end
            if (pv && !pr) begin
                n_cmp++;
                if (out_data !== pd || out_last !== pl) begin
                    n_fail++;
                    $display("FAIL rand_hold: cycle %0d got d=%0d l=%b want d=%0d l=%b", c, out_data, out_last, pd, pl);
                end
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
            pl = out_last;
            commit();
        end
        n_cmp++;
        if (out_cnt != 1280) begin n_fail++; $display("FAIL rand_timeout: got %0d words want 1280", out_cnt); end
        $display("test_random_stalls done: %0d words out", out_cnt);
    endtask

    task automatic test_reset_mid_block();
        do_reset();
        for (int c = 0; c < 200 && (in_cnt < 101 || out_cnt < 10); c++) begin
            drive(in_cnt < 101, (in_cnt >= 64) && (out_cnt < 10));
            commit();
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || bank_full !== 2'b00 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: got v=%b rdy=%b full=%b l=%b want 0 1 00 0", out_valid, in_ready, bank_full, out_last);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        in_cnt  = 0;
        out_cnt = 0;
        for (int c = 0; c < 300 && out_cnt < 64; c++) begin
            drive(in_cnt < 64, 1'b1);
            n_cmp++;
            if (out_valid !== exp_valid() || (exp_valid() && (out_data !== exp_data(out_cnt) || out_last !== (out_cnt == 63)))) begin
                n_fail++;
                $display("FAIL mid_fresh: word %0d got v=%b d=%0d l=%b want v=%b d=%0d", out_cnt, out_valid, out_data, out_last, exp_valid(), exp_data(out_cnt));
            end
            commit();
        end
        n_cmp++;
        if (out_cnt != 64) begin n_fail++; $display("FAIL mid_count: got %0d want 64", out_cnt); end
        $display("test_reset_mid_block done: %0d words out", out_cnt);
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_random_stalls();
        test_reset_mid_block();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_transpose_buffer
